// File: rtl/d_pkg.sv
// Shared types for the d-engine processing path.
//
// Contents:
//   func_e      - engine function codes
//   arb_state_e - state of the function-engine arbiter
//   tag_width() - width of a return-path tag {requester id, last flag}
package d_pkg;

  typedef enum logic [1:0] {
    FnVcordic    = 2'd0,
    FnRcordic    = 2'd1,
    FnReciprocal = 2'd2
  } func_e;

  typedef enum logic {
    StIdle   = 1'b0,
    StLocked = 1'b1
  } arb_state_e;

  // Requester id bits plus one last-of-burst bit.
  function automatic int unsigned tag_width(input int unsigned nreq);
    return $clog2(nreq) + 1;
  endfunction

endpackage

// File: rtl/fwft_sc_fifo.sv
// Single-clock first-word-fall-through FIFO storage.
//
// The word at the head is presented on head_o without a read strobe; a word
// pushed at a clock edge is visible at the head from the following cycle when
// the FIFO was empty. Occupancy is tracked by the caller, which must never push
// when full or pop when empty. DEPTH must be a power of two so the pointers
// wrap naturally.
//
// Ports:
//   clk, rstf   - clock, asynchronous active-low reset (clears pointers)
//   push_i      - write push_data_i at the tail
//   push_data_i - word to write
//   pop_i       - discard the head word
//   head_o      - current head word
module fwft_sc_fifo #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 64
) (
  input  logic             clk,
  input  logic             rstf,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
  end

  always_ff @(posedge clk or negedge rstf) begin
    if (!rstf) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage carries no reset; contents are only observed once pushed.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/d_func_arb.sv
// Round-robin arbiter sharing one in-order math engine among NREQ requesters.
//
// A requester is granted for a whole burst (up to and including its t_last
// beat); the request path is a combinational mux onto the engine input. Every
// accepted beat pushes a tag {requester, last} into an in-order tag queue, and
// each engine result is steered back to the requester named by the head tag.
//
// Ports:
//   clk, rstf          - clock, asynchronous active-low reset
//   t_data/t_last/t_valid/t_ready - per-requester request streams
//   e_tdata/e_tvalid/e_tready     - engine input
//   e_idata/e_ivalid/e_iready     - engine result
//   i_data/i_last      - result data/last, shared by all requesters
//   i_valid/i_ready    - per-requester result handshake
//   grant_id           - current or most recent granted requester
//   busy               - burst in progress or results still outstanding
//   err_orphan         - sticky: engine result arrived with no tag queued
module d_func_arb
  import d_pkg::*;
#(
  parameter int unsigned NREQ      = 2,
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned TAG_DEPTH = 64
) (
  input  logic                    clk,
  input  logic                    rstf,
  input  logic [NREQ*WIDTH-1:0]   t_data,
  input  logic [NREQ-1:0]         t_last,
  input  logic [NREQ-1:0]         t_valid,
  output logic [NREQ-1:0]         t_ready,
  output logic [WIDTH-1:0]        e_tdata,
  output logic                    e_tvalid,
  input  logic                    e_tready,
  input  logic [WIDTH-1:0]        e_idata,
  input  logic                    e_ivalid,
  output logic                    e_iready,
  output logic [WIDTH-1:0]        i_data,
  output logic                    i_last,
  output logic [NREQ-1:0]         i_valid,
  input  logic [NREQ-1:0]         i_ready,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    busy,
  output logic                    err_orphan
);

  localparam int unsigned GW = $clog2(NREQ);
  localparam int unsigned TW = tag_width(NREQ);
  localparam int unsigned CW = $clog2(TAG_DEPTH) + 1;

  arb_state_e       state_q, state_d;
  logic [GW-1:0]    grant_q, grant_d;
  logic [GW-1:0]    rr_q, rr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             err_q, err_d;

  logic             tag_full, tag_empty;
  logic             push, pop;
  logic [TW-1:0]    push_tag, head_tag;
  logic [GW-1:0]    head_id;
  logic             head_last;

  // First requesting index at or after ptr, wrapping. Two passes avoid a
  // modulo on the index.
  function automatic logic [GW-1:0] rr_pick(input logic [NREQ-1:0] req,
                                            input logic [GW-1:0]   ptr);
    logic [GW-1:0] pick;
    logic          found;
    pick  = ptr;
    found = 1'b0;
    for (int unsigned r = 0; r < NREQ; r++) begin
      if (!found && (r >= 32'(ptr)) && req[r]) begin
        pick  = GW'(r);
        found = 1'b1;
      end
    end
    for (int unsigned r = 0; r < NREQ; r++) begin
      if (!found && (r < 32'(ptr)) && req[r]) begin
        pick  = GW'(r);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [GW-1:0] next_id(input logic [GW-1:0] id);
    if (32'(id) == NREQ - 1) return '0;
    return id + GW'(1);
  endfunction

  // Registered occupancy only: a pop in the same cycle does not free a slot
  // for a push, keeping tag_full off the engine-result timing path.
  assign tag_full  = (count_q == CW'(TAG_DEPTH));
  assign tag_empty = (count_q == '0);

  // Request side: grant FSM and burst mux.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_d     = rr_q;
    t_ready  = '0;
    e_tvalid = 1'b0;
    e_tdata  = '0;
    push     = 1'b0;
    push_tag = '0;
    unique case (state_q)
      StIdle: begin
        if (|t_valid) begin
          grant_d = rr_pick(t_valid, rr_q);
          state_d = StLocked;
        end
      end
      StLocked: begin
        for (int unsigned r = 0; r < NREQ; r++) begin
          if (grant_q == GW'(r)) begin
            e_tdata    = t_data[r*WIDTH +: WIDTH];
            e_tvalid   = t_valid[r] & ~tag_full;
            t_ready[r] = e_tready & ~tag_full;
            push       = t_valid[r] & e_tready & ~tag_full;
            push_tag   = {grant_q, t_last[r]};
            if (push && t_last[r]) begin
              rr_d    = next_id(grant_q);
              state_d = StIdle;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Return side: steer the engine result to the head tag's requester.
  assign head_id   = head_tag[TW-1:1];
  assign head_last = head_tag[0];

  always_comb begin
    i_valid  = '0;
    e_iready = 1'b0;
    for (int unsigned r = 0; r < NREQ; r++) begin
      if (head_id == GW'(r)) begin
        i_valid[r] = e_ivalid & ~tag_empty;
        e_iready   = i_ready[r] & ~tag_empty;
      end
    end
  end

  assign pop    = e_ivalid & e_iready;
  assign i_data = e_idata;
  assign i_last = head_last & ~tag_empty;

  always_comb begin
    err_d   = err_q | (e_ivalid & tag_empty);
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstf) begin
    if (!rstf) begin
      state_q <= StIdle;
      grant_q <= '0;
      rr_q    <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  fwft_sc_fifo #(
    .WIDTH(TW),
    .DEPTH(TAG_DEPTH)
  ) u_tag_q (
    .clk        (clk),
    .rstf       (rstf),
    .push_i     (push),
    .push_data_i(push_tag),
    .pop_i      (pop),
    .head_o     (head_tag)
  );

  assign grant_id   = grant_q;
  assign busy       = (state_q == StLocked) | ~tag_empty;
  assign err_orphan = err_q;

endmodule

// File: tb/tb_d_func_arb.sv
module tb_d_func_arb;

  localparam int NREQ      = 2;
  localparam int WIDTH     = 32;
  localparam int TAG_DEPTH = 4;
  localparam int ENG_LAT   = 3;

  typedef struct {
    int unsigned t;
    logic [31:0] d;
  } eng_t;

  typedef struct {
    int          id;
    logic        last;
    logic [31:0] d;
  } res_t;

  logic        clk = 1'b0;
  logic        rstf = 1'b0;
  logic [63:0] t_data;
  logic [1:0]  t_last, t_valid, t_ready;
  logic [31:0] e_tdata;
  logic        e_tvalid, e_tready;
  logic [31:0] e_idata;
  logic        e_ivalid, e_iready;
  logic [31:0] i_data;
  logic        i_last;
  logic [1:0]  i_valid, i_ready;
  logic [0:0]  grant_id;
  logic        busy, err_orphan;

  logic        eng_hv = 1'b0;
  logic [31:0] eng_hd = '0;
  logic        orph, eng_stall;

  eng_t        eq[$];
  logic [31:0] acc_q[$];
  int unsigned acc_c[$];
  res_t        res_q[$];
  int unsigned cyc = 0;
  logic        saw_iv1;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  assign e_ivalid = eng_hv | orph;
  assign e_idata  = eng_hd;

  d_func_arb #(
    .NREQ(NREQ),
    .WIDTH(WIDTH),
    .TAG_DEPTH(TAG_DEPTH)
  ) dut (
    .clk       (clk),
    .rstf      (rstf),
    .t_data    (t_data),
    .t_last    (t_last),
    .t_valid   (t_valid),
    .t_ready   (t_ready),
    .e_tdata   (e_tdata),
    .e_tvalid  (e_tvalid),
    .e_tready  (e_tready),
    .e_idata   (e_idata),
    .e_ivalid  (e_ivalid),
    .e_iready  (e_iready),
    .i_data    (i_data),
    .i_last    (i_last),
    .i_valid   (i_valid),
    .i_ready   (i_ready),
    .grant_id  (grant_id),
    .busy      (busy),
    .err_orphan(err_orphan)
  );

  // Engine model (in order, fixed latency, result = input + 0x100) plus
  // logging of accepted requests and delivered results.
  always @(posedge clk) begin
    cyc++;
    if (!rstf) begin
      eq.delete();
      eng_hv <= 1'b0;
      eng_hd <= '0;
    end else begin
      if (eng_hv && e_iready) void'(eq.pop_front());
      if (e_tvalid && e_tready) begin
        eq.push_back('{t: cyc, d: e_tdata + 32'h100});
        acc_q.push_back(e_tdata);
        acc_c.push_back(cyc);
      end
      for (int r = 0; r < NREQ; r++) begin
        if (i_valid[r] && i_ready[r]) res_q.push_back('{id: r, last: i_last, d: i_data});
      end
      if (i_valid[1]) saw_iv1 = 1'b1;
      eng_hv <= (eq.size() > 0) && !eng_stall && ((cyc - eq[0].t) >= ENG_LAT);
      eng_hd <= (eq.size() > 0) ? eq[0].d : 32'h0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rstf      = 1'b0;
    t_valid   = '0;
    t_last    = '0;
    orph      = 1'b0;
    eng_stall = 1'b0;
    i_ready   = 2'b11;
    tick(2);
    acc_q.delete();
    acc_c.delete();
    res_q.delete();
    saw_iv1 = 1'b0;
    rstf    = 1'b1;
  endtask

  task automatic send_burst(input int r, input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      int w;
      t_valid[r] = 1'b1;
      t_data[r*32 +: 32] = base + 32'(i);
      t_last[r] = (i == n - 1);
      w = 0;
      #1;
      while (!t_ready[r] && w < 50) begin
        @(negedge clk);
        #1;
        w++;
      end
      chk($sformatf("handshake r%0d beat %0d", r, i), t_ready[r], 1'b1);
      @(negedge clk);
    end
    t_valid[r] = 1'b0;
    t_last[r]  = 1'b0;
  endtask

  task automatic wait_res(input int n);
    int w;
    w = 0;
    while (res_q.size() < n && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("result count", res_q.size(), n);
  endtask

  task automatic chk_res(input string tag, input int idx, input int id, input logic [31:0] d,
                         input logic last);
    if (idx < res_q.size()) begin
      chk({tag, " id"}, res_q[idx].id, id);
      chk({tag, " data"}, res_q[idx].d, d);
      chk({tag, " last"}, res_q[idx].last, last);
    end else begin
      chk({tag, " missing"}, res_q.size(), idx + 1);
    end
  endtask

  initial begin
    t_data   = '0;
    e_tready = 1'b1;

    // Reset state.
    do_reset();
    #1;
    chk("rst t_ready", t_ready, 2'b00);
    chk("rst i_valid", i_valid, 2'b00);
    chk("rst e_tvalid", e_tvalid, 1'b0);
    chk("rst e_iready", e_iready, 1'b0);
    chk("rst grant_id", grant_id, 1'b0);
    chk("rst busy", busy, 1'b0);
    chk("rst err_orphan", err_orphan, 1'b0);

    // Single requester burst of 4; nothing accepted while IDLE.
    t_valid[0] = 1'b1;
    t_data[31:0] = 32'h1;
    t_last[0] = 1'b0;
    #1;
    chk("t1 idle t_ready", t_ready, 2'b00);
    chk("t1 idle e_tvalid", e_tvalid, 1'b0);
    send_burst(0, 4, 32'h1);
    wait_res(4);
    for (int i = 0; i < 4; i++) chk_res("t1", i, 0, 32'h101 + 32'(i), i == 3);
    chk("t1 no i_valid[1]", saw_iv1, 1'b0);
    tick(2);
    #1;
    chk("t1 idle busy", busy, 1'b0);

    // Contention from reset: req0 first, one bubble, then req1; then req0 again.
    do_reset();
    fork
      send_burst(0, 2, 32'h10);
      send_burst(1, 2, 32'h20);
      begin
        @(negedge clk);
        #1;
        chk("t2 first grant", grant_id, 1'b0);
        chk("t2 first t_ready", t_ready, 2'b01);
      end
    join
    chk("t2 acc count", acc_q.size(), 4);
    chk("t2 acc1", acc_q[1], 32'h11);
    chk("t2 acc2", acc_q[2], 32'h20);
    chk("t2 bubble", acc_c[2] - acc_c[1], 2);
    chk("t2 second grant", grant_id, 1'b1);
    fork
      send_burst(0, 1, 32'h30);
      send_burst(1, 1, 32'h40);
    join
    chk("t2 rr wrap acc4", acc_q[4], 32'h30);
    chk("t2 rr wrap acc5", acc_q[5], 32'h40);
    wait_res(6);
    chk_res("t2 r0", 0, 0, 32'h110, 1'b0);
    chk_res("t2 r2", 2, 1, 32'h120, 1'b0);
    chk_res("t2 r3", 3, 1, 32'h121, 1'b1);
    chk_res("t2 r5", 5, 1, 32'h140, 1'b1);

    // Burst lock: req1 waits for req0's 8-beat burst to finish.
    do_reset();
    fork
      send_burst(0, 8, 32'h50);
      begin
        tick(3);
        t_valid[1] = 1'b1;
        t_data[63:32] = 32'h60;
        t_last[1] = 1'b0;
        #1;
        chk("t3 locked out", t_ready[1], 1'b0);
        send_burst(1, 2, 32'h60);
      end
    join
    chk("t3 acc7", acc_q[7], 32'h57);
    chk("t3 acc8", acc_q[8], 32'h60);
    wait_res(10);
    chk_res("t3 r7", 7, 0, 32'h157, 1'b1);
    chk_res("t3 r8", 8, 1, 32'h160, 1'b0);

    // Tag queue full: engine results stalled, 6-beat burst into depth 4.
    do_reset();
    eng_stall = 1'b1;
    fork
      send_burst(0, 6, 32'h70);
      begin
        int w;
        w = 0;
        while (acc_q.size() < 4 && w < 50) begin
          @(negedge clk);
          w++;
        end
        tick(3);
        #2;
        chk("t4 accepted while full", acc_q.size(), 4);
        chk("t4 t_ready full", t_ready[0], 1'b0);
        chk("t4 e_tvalid full", e_tvalid, 1'b0);
        chk("t4 busy", busy, 1'b1);
        eng_stall = 1'b0;
      end
    join
    wait_res(6);
    for (int i = 0; i < 6; i++) chk_res("t4", i, 0, 32'h170 + 32'(i), i == 5);

    // Head result for a stalled requester blocks results behind it.
    do_reset();
    i_ready = 2'b01;
    send_burst(1, 1, 32'h80);
    send_burst(0, 2, 32'h90);
    tick(8);
    #1;
    chk("t5 i_valid held", i_valid, 2'b10);
    chk("t5 e_iready held", e_iready, 1'b0);
    chk("t5 i_data held", i_data, 32'h180);
    chk("t5 i_last held", i_last, 1'b1);
    chk("t5 nothing delivered", res_q.size(), 0);
    i_ready = 2'b11;
    wait_res(3);
    chk_res("t5 r0", 0, 1, 32'h180, 1'b1);
    chk_res("t5 r1", 1, 0, 32'h190, 1'b0);
    chk_res("t5 r2", 2, 0, 32'h191, 1'b1);

    // Orphan result with an empty tag queue.
    do_reset();
    orph = 1'b1;
    #1;
    chk("t6 orphan i_valid", i_valid, 2'b00);
    chk("t6 orphan e_iready", e_iready, 1'b0);
    @(negedge clk);
    orph = 1'b0;
    #1;
    chk("t6 err set", err_orphan, 1'b1);
    tick(2);
    #1;
    chk("t6 err sticky", err_orphan, 1'b1);
    rstf = 1'b0;
    #1;
    chk("t6 err cleared", err_orphan, 1'b0);
    chk("t6 busy cleared", busy, 1'b0);
    tick(1);
    rstf = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
